// File: rtl/spi_tx16.sv
// ---------------------------------------------------------------------------
// spi_tx16 - SPI (mode 0) master transmitter, 16-bit words, MSB first.
//
// Accepts a word through a valid/ready handshake and sends it on a
// CS/SCK/MOSI link. SCK half-period is DIV clk cycles. After each frame CS is
// held high for at least GAP clk cycles.
//
// Parameters:
//   DIV  SPI clock half-period in clk cycles (1..255)
//   GAP  minimum clk cycles with spi_cs high between frames (1..255)
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   tx_data   word to send (bit 15 first)
//   tx_valid  tx_data is offered
//   tx_ready  a word is accepted this cycle when tx_valid is high
//   busy      frame, gap or buffered word in progress
//   done      one-cycle pulse in the first cycle with spi_cs high again
//   spi_cs    active-low chip select
//   spi_clk   SPI clock, idle low
//   spi_mosi  serial data
//
// Build option:
//   SPI_TX16_BUF_EN  adds a one-word holding buffer so the next word can be
//                    accepted while a frame is in flight.
// ---------------------------------------------------------------------------
module spi_tx16 #(
    parameter int unsigned DIV = 4,
    parameter int unsigned GAP = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_mosi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  phase;
    logic [7:0]  phase_next;
    logic [15:0] shreg;
    logic [3:0]  bit_cnt;
    logic        transfer;
    logic        load_tx;
    logic        load_buf;
    logic        shift_en;
    logic        buf_full;
    logic [15:0] buf_word;
    logic        frame_active;

    assign transfer = tx_valid && tx_ready;

`ifdef SPI_TX16_BUF_EN
    logic buf_store;

    // A word accepted while it cannot go straight into the shift register
    // parks here; the buffer is only writable while empty.
    assign buf_store = transfer && !load_tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_word <= '0;
        end else if (buf_store) begin
            buf_full <= 1'b1;
            buf_word <= tx_data;
        end else if (load_buf) begin
            buf_full <= 1'b0;
        end
    end

    assign tx_ready = !buf_full;
`else
    assign buf_full = 1'b0;
    assign buf_word = '0;
    assign tx_ready = (state == S_IDLE);
`endif

    // Next-state logic. The phase counter restarts on every state change.
    always_comb begin
        state_next = state;
        phase_next = (state == S_IDLE) ? 8'd0 : phase + 8'd1;
        load_tx    = 1'b0;
        load_buf   = 1'b0;
        shift_en   = 1'b0;

        case (state)
            S_IDLE: begin
                if (transfer) begin
                    state_next = S_SETUP;
                    load_tx    = 1'b1;
                end
            end
            S_SETUP: begin
                if (phase == DIV_LAST) state_next = S_HIGH;
            end
            S_HIGH: begin
                if (phase == DIV_LAST) begin
                    // Last bit already presented: keep MOSI steady into HOLD.
                    if (bit_cnt == 4'd0) begin
                        state_next = S_HOLD;
                    end else begin
                        state_next = S_LOW;
                        shift_en   = 1'b1;
                    end
                end
            end
            S_LOW: begin
                if (phase == DIV_LAST) state_next = S_HIGH;
            end
            S_HOLD: begin
                if (phase == DIV_LAST) state_next = S_GAP;
            end
            S_GAP: begin
                if (phase == GAP_LAST) begin
                    if (buf_full) begin
                        state_next = S_SETUP;
                        load_buf   = 1'b1;
                    end else if (transfer) begin
                        // Only reachable with the buffer: a word offered in
                        // the last gap cycle goes straight to the shifter.
                        state_next = S_SETUP;
                        load_tx    = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (state_next != state) phase_next = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            phase   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_next;
            phase <= phase_next;
            if (load_tx) begin
                shreg   <= tx_data;
                bit_cnt <= 4'd15;
            end else if (load_buf) begin
                shreg   <= buf_word;
                bit_cnt <= 4'd15;
            end else if (shift_en) begin
                shreg   <= {shreg[14:0], 1'b0};
                bit_cnt <= bit_cnt - 4'd1;
            end
        end
    end

    // Outputs are decoded from the state register, so MOSI and CS only move
    // on the same edge that takes SCK low (or while SCK is already low).
    assign frame_active = (state == S_SETUP) || (state == S_HIGH) ||
                          (state == S_LOW)   || (state == S_HOLD);
    assign spi_cs   = !frame_active;
    assign spi_clk  = (state == S_HIGH);
    assign spi_mosi = frame_active && shreg[15];
    assign done     = (state == S_GAP) && (phase == 8'd0);
    assign busy     = (state != S_IDLE) || buf_full;

endmodule

// File: tb/tb_spi_tx16.sv
// ---------------------------------------------------------------------------
// tb_spi_tx16 - self-checking bench for spi_tx16.
//
// Three instances with DIV = 1, 2, 3 and GAP = 4 share clk/reset. Each has
// a receiver model (mode-0 slave: samples MOSI on SCK rise, word complete on
// CS rise) that pushes frame records; the stimulus pushes expected words.
// Expectations follow the build: define SPI_TX16_BUF_EN for the buffered RTL.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_tx16;

    localparam int N    = 3;
    localparam int GAPC = 4;

`ifdef SPI_TX16_BUF_EN
    localparam int B2B_SPACING = 1;      // second word taken during SETUP
    localparam int B2B_CS_HIGH = GAPC;   // no IDLE cycle between frames
    localparam int READY_WAIT  = 0;      // ready stays high while buffer empty
`else
    localparam int B2B_SPACING = 33 + GAPC + 1;
    localparam int B2B_CS_HIGH = GAPC + 1;  // GAP cycles plus the IDLE cycle
    localparam int READY_WAIT  = 33 * 2 + GAPC;
`endif

    typedef struct packed {
        int          g;
        logic [15:0] w;
        int          nbits;
        int          low;
        int          high;
        logic        dn;
    } frame_t;

    typedef struct packed {
        int          g;
        logic [15:0] w;
    } exp_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        mon_en = 1'b0;
    logic [15:0] tx_data  [N];
    logic        tx_valid [N];
    logic        tx_ready [N];
    logic        busy     [N];
    logic        done     [N];
    logic        spi_cs   [N];
    logic        spi_clk  [N];
    logic        spi_mosi [N];
    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;
    frame_t      rx_q[$];
    exp_t        exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_tx16 #(.DIV(g + 1), .GAP(GAPC)) dut (
            .clk      (clk),
            .reset    (reset),
            .tx_data  (tx_data[g]),
            .tx_valid (tx_valid[g]),
            .tx_ready (tx_ready[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .spi_cs   (spi_cs[g]),
            .spi_clk  (spi_clk[g]),
            .spi_mosi (spi_mosi[g])
        );

        logic        pcs   = 1'b1;
        logic        pclk  = 1'b0;
        logic        pmosi = 1'b0;
        logic [15:0] sr    = '0;
        int          nb = 0, low = 0, high = 0, hb = 0;
        int          glitch = 0, done_cnt = 0;
        frame_t      rec;

        always @(negedge clk) begin
            if (mon_en) begin
                if (spi_clk[g] === 1'b1 &&
                    (spi_mosi[g] !== pmosi || spi_cs[g] !== pcs))
                    glitch++;
                if (done[g] === 1'b1) done_cnt++;
                if (spi_cs[g] === 1'b0) begin
                    if (pcs === 1'b1) begin
                        hb  = high;
                        nb  = 0;
                        low = 0;
                    end
                    low++;
                    if (spi_clk[g] === 1'b1 && pclk === 1'b0) begin
                        sr = {sr[14:0], spi_mosi[g]};
                        nb++;
                    end
                end else begin
                    if (pcs === 1'b0) begin
                        rec.g     = g;
                        rec.w     = sr;
                        rec.nbits = nb;
                        rec.low   = low;
                        rec.high  = hb;
                        rec.dn    = done[g];
                        rx_q.push_back(rec);
                        high = 0;
                    end
                    high++;
                end
                pcs   = spi_cs[g];
                pclk  = spi_clk[g];
                pmosi = spi_mosi[g];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer w to instance g from a negedge; returns at the negedge after the
    // accepting edge, with t_acc holding the cycle count of that edge.
    task automatic send(input int g, input logic [15:0] w, output int t_acc);
        int   n = 0;
        exp_t e;
        tx_data[g]  = w;
        tx_valid[g] = 1'b1;
        while (tx_ready[g] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", 32'(n < 3000), 1);
        @(posedge clk);
        #1;
        t_acc       = cyc;
        tx_valid[g] = 1'b0;
        tx_data[g]  = 16'($urandom);
        e.g = g;
        e.w = w;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_frame(output frame_t f, output exp_t e);
        int n = 0;
        while (rx_q.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", 32'(n < 3000), 1);
        if (rx_q.size() != 0) f = rx_q.pop_front();
        else begin
            f   = '0;
            f.g = -1;
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else begin
            e   = '0;
            e.g = -1;
        end
    endtask

    task automatic check_frame(input string tag, input int low_exp,
                               output frame_t f);
        exp_t e;
        wait_frame(f, e);
        check({tag, "_word"}, 32'(f.w), 32'(e.w));
        check({tag, "_inst"}, f.g, e.g);
        check({tag, "_bits"}, f.nbits, 16);
        check({tag, "_cs_low"}, f.low, low_exp);
        check({tag, "_done"}, 32'(f.dn), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        exp_t   e;
        int     t0, t1, n, bad, d0;

        for (int i = 0; i < N; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = '0;
        end

        // Reset, then idle
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_cs",    32'(spi_cs[1]),   1);
        check("rst_clk",   32'(spi_clk[1]),  0);
        check("rst_mosi",  32'(spi_mosi[1]), 0);
        check("rst_ready", 32'(tx_ready[1]), 1);
        check("rst_busy",  32'(busy[1]),     0);
        check("rst_done",  32'(done[1]),     0);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (spi_cs[i] !== 1'b1 || spi_clk[i] !== 1'b0 ||
                    spi_mosi[i] !== 1'b0 || tx_ready[i] !== 1'b1 ||
                    busy[i] !== 1'b0 || done[i] !== 1'b0)
                    bad++;
        end
        check("idle_hold", bad, 0);

        // Single word 0xA5C3, DIV=2
        d0 = g_dut[1].done_cnt;
        send(1, 16'hA5C3, t0);
        check("a5c3_cs_fall",   32'(spi_cs[1]),   0);
        check("a5c3_first_bit", 32'(spi_mosi[1]), 1);
        check("a5c3_busy",      32'(busy[1]),     1);
        n = 0;
        while (tx_ready[1] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("a5c3_ready_return", n, READY_WAIT);
        check_frame("a5c3", 66, f);
        repeat (8) @(negedge clk);
        check("a5c3_done_pulses", g_dut[1].done_cnt - d0, 1);

        // Back-to-back 0xFFFF, 0x0001 on DIV=1
        send(0, 16'hFFFF, t0);
        send(0, 16'h0001, t1);
        check("b2b_accept_spacing", t1 - t0, B2B_SPACING);
`ifdef SPI_TX16_BUF_EN
        check("b2b_ready_full", 32'(tx_ready[0]), 0);
        n = 0;
        while (tx_ready[0] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain_cycles", n, 36);
`endif
        check_frame("b2b_first", 33, f);
        check_frame("b2b_second", 33, f);
        check("b2b_cs_high_gap", f.high, B2B_CS_HIGH);

        // Reset ~20 cycles into a 0x1234 frame, DIV=2
        repeat (10) @(negedge clk);
        d0 = g_dut[1].done_cnt;
        send(1, 16'h1234, t0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_cs",   32'(spi_cs[1]),  1);
        check("midrst_clk",  32'(spi_clk[1]), 0);
        check("midrst_done", 32'(done[1]),    0);
        check("midrst_busy", 32'(busy[1]),    0);
        reset = 1'b0;
        wait_frame(f, e);
        check("midrst_partial", 32'(f.nbits < 16), 1);
        check("midrst_rise_done", 32'(f.dn), 0);
        repeat (10) @(negedge clk);
        check("midrst_no_done", g_dut[1].done_cnt - d0, 0);
        send(1, 16'h0F0F, t0);
        check_frame("after_rst", 66, f);

        // Random words on every divider
        for (int g = 0; g < N; g++) begin
            for (int k = 0; k < 3; k++) begin
                send(g, 16'($urandom), t0);
                check_frame("rand", 33 * (g + 1), f);
            end
        end
        repeat (10) @(negedge clk);
        check("glitch_div1", g_dut[0].glitch, 0);
        check("glitch_div2", g_dut[1].glitch, 0);
        check("glitch_div3", g_dut[2].glitch, 0);
        check("stray_frames", rx_q.size(), 0);
        check("missing_frames", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
